// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, press/release debounce, BCD entry.
// Define KEYPAD_AUTOREPEAT_EN to re-accept a held key every REPEAT_CYC clocks.
module keypad_scanner #(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CYC = 100000,
    parameter int REPEAT_CYC   = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       enter,
    output logic [3:0] Ds,
    output logic [3:0] Us
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state, state_d;
    logic [3:0]    col_s1, col_q;
    logic [3:0]    col_pat, pat_d;
    logic [1:0]    row_idx, idx_d;
    logic [1:0]    col_idx;
    logic [DW-1:0] div_cnt, div_d;
    logic [CW-1:0] deb_cnt, deb_d;
    logic          accept;
    logic [3:0]    key_sel;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
    logic [RW-1:0] rep_cnt, rep_d;
`endif

    generate
        if (SCAN_DIV < 2 || DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
            $error("keypad_scanner: invalid parameter value");
        end
    endgenerate

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        unique case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest set column wins when several are pressed in the driven row
    always_comb begin
        col_idx = 2'd3;
        if (col_pat[0])
            col_idx = 2'd0;
        else if (col_pat[1])
            col_idx = 2'd1;
        else if (col_pat[2])
            col_idx = 2'd2;
    end

    assign key_sel = key_map(row_idx, col_idx);
    assign row     = 4'b0001 << row_idx;

    always_comb begin
        state_d = state;
        idx_d   = row_idx;
        pat_d   = col_pat;
        div_d   = '0;
        deb_d   = '0;
        accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = '0;
`endif
        unique case (state)
            SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    if (col_q != 4'd0) begin
                        pat_d   = col_q;
                        state_d = DEBOUNCE;
                    end else begin
                        idx_d = row_idx + 2'd1;
                    end
                end else begin
                    div_d = div_cnt + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (col_q != col_pat) begin
                    state_d = SCAN;
                    idx_d   = row_idx + 2'd1;
                end else if (deb_cnt == DEB_LAST) begin
                    accept  = 1'b1;
                    state_d = HELD;
                end else begin
                    deb_d = deb_cnt + CW'(1);
                end
            end
            HELD: begin
                if (col_q == 4'd0) begin
                    state_d = RELEASE;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rep_cnt == REP_LAST) begin
                    accept = 1'b1;
                end else begin
                    rep_d = rep_cnt + RW'(1);
                end
`endif
            end
            RELEASE: begin
                if (col_q != 4'd0) begin
                    state_d = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d = SCAN;
                    idx_d   = row_idx + 2'd1;
                end else begin
                    deb_d = deb_cnt + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            row_idx <= 2'd0;
            col_pat <= 4'd0;
            div_cnt <= '0;
            deb_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state   <= state_d;
            row_idx <= idx_d;
            col_pat <= pat_d;
            div_cnt <= div_d;
            deb_cnt <= deb_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= rep_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1    <= 4'd0;
            col_q     <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            enter     <= 1'b0;
            Ds        <= 4'd0;
            Us        <= 4'd0;
        end else begin
            col_s1    <= col;
            col_q     <= col_s1;
            key_valid <= accept;
            enter     <= accept && (key_sel == 4'hF);
            if (accept) begin
                key_code <= key_sel;
                if (key_sel <= 4'd9) begin
                    Ds <= Us;
                    Us <= key_sel;
                end else if (key_sel == 4'hE) begin
                    Ds <= 4'd0;
                    Us <= 4'd0;
                end
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 5000: clocks each row is driven before the scan advances; minimum 2.
REQ-002 Parameter DEBOUNCE_CYC, default 100000: consecutive stable samples required for press and for release.
REQ-003 Parameter REPEAT_CYC, default 2500000: auto-repeat period in clocks; used only when KEYPAD_AUTOREPEAT_EN is defined.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 col  input  4  keypad column sense, active-high; pulled low externally when open; asynchronous, double-flop synchronised internally.
REQ-007 row  output  4  row drive, active-high one-hot.
REQ-008 key_code  output  4  code of the last accepted key.
REQ-009 key_valid  output  1  one-clock pulse per accepted key.
REQ-010 enter  output  1  one-clock pulse when '#' is accepted.
REQ-011 Ds  output  4  BCD tens digit of the entry register.
REQ-012 Us  output  4  BCD units digit of the entry register.

Function
REQ-013 Key map (row,col) -> code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: *,0,#,D.
REQ-014 Key codes: digits = value; A..D = 0xA..0xD; '*' = 0xE; '#' = 0xF.
REQ-015 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 SCAN: row index advances 0->1->2->3->0 every SCAN_DIV clocks.
REQ-017 SCAN: synchronised col is sampled on the last dwell clock of each row.
REQ-018 SCAN: a nonzero col sample latches row index and col pattern, freezes row, and moves to DEBOUNCE.
REQ-019 Multiple columns high: lowest-index column selects the key.
REQ-020 Multiple rows pressed: only the currently driven row is seen.
REQ-021 DEBOUNCE: counts consecutive clocks where col equals the latched pattern.
REQ-022 DEBOUNCE: any mismatch returns to SCAN with the row index advanced; no key is emitted.
REQ-023 Press acceptance: on the clock after DEBOUNCE_CYC matches, key_valid=1 for one clock, key_code and entry update on the same edge, FSM moves to HELD.
REQ-024 HELD: any clock with col==0 moves to RELEASE.
REQ-025 RELEASE: requires DEBOUNCE_CYC consecutive col==0 clocks, then returns to SCAN with the row index advanced; any nonzero col returns to HELD.
REQ-026 Entry, digit key: Ds<=Us and Us<=digit (shift left); the old Ds is discarded.
REQ-027 Entry, '*': Ds=Us=0.
REQ-028 Entry, '#': Ds and Us unchanged; enter pulses coincident with key_valid.
REQ-029 Entry, A..D: key_valid only; Ds and Us unchanged.
REQ-030 Ds and Us are always valid BCD (0..9).
REQ-031 All counters saturate or reset on state change; none wraps within a state.

Reset
REQ-032 With rst_n low: FSM=SCAN, row index 0, row=4'b0001, key_code=0, key_valid=0, enter=0, Ds=0, Us=0, all counters and synchronisers cleared.
REQ-033 Reset asserted mid-DEBOUNCE, HELD or RELEASE aborts with no pulse emitted.
REQ-034 After reset release, a key still held must pass a full DEBOUNCE from SCAN before it is accepted.

Configuration
REQ-035 Macro KEYPAD_AUTOREPEAT_EN, when defined: in HELD, after REPEAT_CYC continuous held clocks, the same key is re-accepted (key_valid, entry update, enter for '#'), then again every REPEAT_CYC clocks until release.
REQ-036 Macro KEYPAD_AUTOREPEAT_EN, when undefined: exactly one key_valid per press; the repeat counter is absent.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=32)
REQ-037 Press '5' (row1, col=0010) steady, then release -> one key_valid with key_code=5; Us=5, Ds=0; no further pulse.
REQ-038 Sequence 4, 2, 7 with clean releases -> Ds:Us = 0:4, 4:2, 2:7; '*' -> 0:0.
REQ-039 col bounces 0010/0000 every 3 clocks for 40 clocks -> no key_valid; scan keeps cycling.
REQ-040 '#' press -> key_valid and enter high on the same clock, key_code=0xF, Ds/Us unchanged.
REQ-041 Keys '1' and '3' in row0 together -> key_code=1; rst_n pulsed low during HELD -> all outputs 0, row=0001, no pulse until a new full debounce completes.
REQ-042 KEYPAD_AUTOREPEAT_EN defined, '8' held 100 clocks after acceptance -> 3 additional key_valid pulses 32 clocks apart, final Ds:Us=8:8; macro undefined -> 1 pulse only.
